tbird_light_seq: RTL
====================

Name: tbird_light_seq

Overview:
- Tail-light sequencer for the Thunderbird turn-signal design.
- Sits directly downstream of the clock-enable divider and advances only on its one-cycle clk_en pulse.
- Drives the three left and three right lamps (A = innermost, C = outermost) through the classic left, right and hazard patterns from synchronised switch inputs.

Parameters:
- SYNC_STAGES, 2: flip-flop depth of each input synchroniser; legal values are 2 or more.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- clk_en  in  1  one-cycle step pulse from the upstream divider
- left  in  1  left-turn switch, asynchronous
- right  in  1  right-turn switch, asynchronous
- haz  in  1  hazard switch, asynchronous
- l_lights  out  3  {LC,LB,LA}
- r_lights  out  3  {RC,RB,RA}
- busy  out  1  high whenever the state is not IDLE

Behaviour:
- Synchronisers:
  - left, right and haz each pass through a SYNC_STAGES flip-flop chain clocked on every clk.
  - The FSM sees only the synchronised copies (ls, rs, hs).
  - An input change is visible to the FSM SYNC_STAGES cycles after it is sampled.
- States: IDLE, L1, L2, L3, R1, R2, R3, LR3. The state register updates only in cycles where clk_en=1; otherwise it holds.
- Transitions, evaluated when clk_en=1:
  - IDLE:
    - hs=1, or ls=1 and rs=1: go to LR3.
    - Otherwise ls=1: go to L1.
    - Otherwise rs=1: go to R1.
    - Otherwise stay in IDLE.
  - L1 goes to L2, and L2 goes to L3. If hs=1 in L1 or L2, go to LR3 instead (hazard overrides).
  - R1 goes to R2, and R2 goes to R3, with the same hazard override.
  - L3, R3 and LR3 always go to IDLE, so lamps blink off for one step between sequences.
  - Releasing left or right mid-sequence does not abort it. The sequence runs to L3/R3 and then returns to IDLE.
- Outputs (Moore, decoded combinationally from the state register, no added latency):
  - IDLE: l=000, r=000
  - L1: l=001; L2: l=011; L3: l=111; r=000 in all three
  - R1: r=001; R2: r=011; R3: r=111; l=000 in all three
  - LR3: l=111, r=111
  - busy = (state != IDLE)
- clk_en held high continuously is legal. The FSM then steps every clk.
- Reset:
  - rst=1 forces IDLE, all synchroniser flops to 0, and l_lights, r_lights and busy to 0.
  - This takes effect immediately, including mid-sequence.
  - After rst is released, the first step occurs on the first clk_en=1 edge.
- Illegal or unreachable state encodings return to IDLE on the next clk_en and output 000/000 meanwhile.

Decomposition:
- Shared package tbird_pkg holds:
  - the state enum (3-bit encoding)
  - lamp pattern constants PAT_OFF=000, PAT_1=001, PAT_2=011, PAT_3=111
- One sub-module, sync_ff: a single-bit, parameterised-depth synchroniser with asynchronous reset. It is instanced three times.
- The top level holds the FSM and the output decode.

Test Plan:
- Left sequence: rst pulse, bench clk_en every 4 clk, left=1 held. Required l_lights 000, 001, 011, 111, 000, 001, ... stepping on successive clk_en edges; r_lights stays 000; busy=0 only in IDLE.
- Right release mid-run: right=1 until state R1, then right=0. Required r_lights 001, 011, 111, 000, then stays 000 with busy=0.
- Hazard override: left=1 until L2 is reached, then haz=1. Required next step gives l=111, r=111 (LR3), then 000/000, then LR3 again while haz is held.
- Left and right together: left=right=1, haz=0 from IDLE. Required output alternates 111/111 and 000/000 on each clk_en.
- No clk_en: left=1 for 50 cycles with clk_en=0. Required state stays IDLE and outputs stay 000/000. A single clk_en pulse then gives l=001 at the following edge.
- Reset mid-operation: assert rst asynchronously (between clk edges) while in L3. Required l=000, r=000 and busy=0 immediately. After release with left=1, the first clk_en gives 001, accounting for SYNC_STAGES=2 cycles of synchroniser refill.

Source files
------------

// File: rtl/tbird_pkg.sv
// Shared types and lamp patterns for the Thunderbird tail-light sequencer.
package tbird_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned LAMP_W  = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 3'd0,
    L1   = 3'd1,
    L2   = 3'd2,
    L3   = 3'd3,
    R1   = 3'd4,
    R2   = 3'd5,
    R3   = 3'd6,
    LR3  = 3'd7
  } state_t;

  localparam logic [LAMP_W-1:0] PAT_OFF = 3'b000;
  localparam logic [LAMP_W-1:0] PAT_1   = 3'b001;
  localparam logic [LAMP_W-1:0] PAT_2   = 3'b011;
  localparam logic [LAMP_W-1:0] PAT_3   = 3'b111;

endpackage

// File: rtl/sync_ff.sv
// Single-bit multi-flop synchroniser with asynchronous reset to 0.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/tbird_light_seq.sv
// Tail-light sequencer: steps left/right/hazard lamp patterns on each clk_en pulse.
module tbird_light_seq
  import tbird_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              left,
  input  logic              right,
  input  logic              haz,
  output logic [LAMP_W-1:0] l_lights,
  output logic [LAMP_W-1:0] r_lights,
  output logic              busy
);

  logic   ls, rs, hs;
  state_t state_q, state_d;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_left  (.clk(clk), .rst(rst), .d(left),  .q(ls));
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_right (.clk(clk), .rst(rst), .d(right), .q(rs));
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_haz   (.clk(clk), .rst(rst), .d(haz),   .q(hs));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         state_q <= IDLE;
    else if (clk_en) state_q <= state_d;
  end

  // Next state; hazard wins over an in-progress turn sequence.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE: begin
        if (hs || (ls && rs)) state_d = LR3;
        else if (ls)          state_d = L1;
        else if (rs)          state_d = R1;
        else                  state_d = IDLE;
      end
      L1:      state_d = hs ? LR3 : L2;
      L2:      state_d = hs ? LR3 : L3;
      R1:      state_d = hs ? LR3 : R2;
      R2:      state_d = hs ? LR3 : R3;
      L3, R3, LR3: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore lamp decode straight from the state register.
  always_comb begin
    l_lights = PAT_OFF;
    r_lights = PAT_OFF;
    case (state_q)
      L1:  l_lights = PAT_1;
      L2:  l_lights = PAT_2;
      L3:  l_lights = PAT_3;
      R1:  r_lights = PAT_1;
      R2:  r_lights = PAT_2;
      R3:  r_lights = PAT_3;
      LR3: begin
        l_lights = PAT_3;
        r_lights = PAT_3;
      end
      default: begin
        l_lights = PAT_OFF;
        r_lights = PAT_OFF;
      end
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule
